// File: rtl/bcd_pkg.sv
// Constants shared by the binary<->BCD converters.
// Also holds the FSM state encoding.
package bcd_pkg;

    localparam int N_DIG   = 4;
    localparam int W_BIN   = 14;
    localparam int DIG_W   = 4;
    localparam int DIG_MAX = 9;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_OP   = 2'b01,
        ST_DONE = 2'b10
    } state_t;

endpackage

// File: rtl/bcd_digit_adj.sv
// Reverse double-dabble digit corrector.
// After a right shift, any digit >= 8 has 3 subtracted from it.
module bcd_digit_adj
    import bcd_pkg::*;
(
    input  logic [DIG_W-1:0] din,
    output logic [DIG_W-1:0] dout
);

    assign dout = (din >= DIG_W'(8)) ? (din - DIG_W'(3)) : din;

endmodule

// File: rtl/bcd2bin.sv
// Iterative 4-digit BCD to 14-bit binary converter.
// Runs reverse double-dabble and produces one result bit per clock.
module bcd2bin
    import bcd_pkg::*;
(
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic [DIG_W-1:0] bcd3,
    input  logic [DIG_W-1:0] bcd2,
    input  logic [DIG_W-1:0] bcd1,
    input  logic [DIG_W-1:0] bcd0,
    output logic             ready,
    output logic             done_tick,
    output logic             err,
    output logic [W_BIN-1:0] bin
);

    localparam int BCD_W = N_DIG * DIG_W;
    localparam int SH_W  = BCD_W + W_BIN;
    localparam int CNT_W = $clog2(W_BIN + 1);

    state_t             state;
    logic [BCD_W-1:0]   bcd_reg;
    logic [W_BIN-1:0]   bin_reg;
    logic [CNT_W-1:0]   n_reg;
    logic               err_reg;

    logic [BCD_W-1:0]   bcd_in;
    logic               digits_ok;
    logic [SH_W-1:0]    shifted;
    logic [BCD_W-1:0]   bcd_adj;
    logic [CNT_W-1:0]   n_next;

    assign bcd_in  = {bcd3, bcd2, bcd1, bcd0};
    assign shifted = {bcd_reg, bin_reg} >> 1;
    assign n_next  = n_reg - CNT_W'(1);

    always_comb begin
        digits_ok = 1'b1;
        for (int i = 0; i < N_DIG; i++) begin
            if (bcd_in[i*DIG_W +: DIG_W] > DIG_W'(DIG_MAX))
                digits_ok = 1'b0;
        end
    end

    // Each digit of the shifted BCD field is corrected independently.
    for (genvar g = 0; g < N_DIG; g++) begin : g_adj
        bcd_digit_adj u_adj (
            .din  (shifted[W_BIN + g*DIG_W +: DIG_W]),
            .dout (bcd_adj[g*DIG_W +: DIG_W])
        );
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state   <= ST_IDLE;
            bcd_reg <= '0;
            bin_reg <= '0;
            n_reg   <= '0;
            err_reg <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        bin_reg <= '0;
                        if (digits_ok) begin
                            bcd_reg <= bcd_in;
                            n_reg   <= CNT_W'(W_BIN);
                            err_reg <= 1'b0;
                            state   <= ST_OP;
                        end else begin
                            err_reg <= 1'b1;
                            state   <= ST_DONE;
                        end
                    end
                end
                ST_OP: begin
                    bcd_reg <= bcd_adj;
                    bin_reg <= shifted[W_BIN-1:0];
                    n_reg   <= n_next;
                    if (n_next == '0)
                        state <= ST_DONE;
                end
                ST_DONE: state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign ready     = (state == ST_IDLE);
    assign done_tick = (state == ST_DONE);
    assign err       = err_reg;
    assign bin       = bin_reg;

endmodule

// File: tb/tb_bcd2bin.sv
// Directed-vector bench for bcd2bin with hand-computed results.
module tb_bcd2bin;
    import bcd_pkg::*;

    logic             clk = 1'b0;
    logic             reset_n;
    logic             start;
    logic [3:0]       bcd3, bcd2, bcd1, bcd0;
    logic             ready, done_tick, err;
    logic [W_BIN-1:0] bin;

    int n_vec = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    bcd2bin dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .start     (start),
        .bcd3      (bcd3),
        .bcd2      (bcd2),
        .bcd1      (bcd1),
        .bcd0      (bcd0),
        .ready     (ready),
        .done_tick (done_tick),
        .err       (err),
        .bin       (bin)
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Apply one start pulse and follow the conversion to its done tick.
    // exp_lat counts clock edges from acceptance until done_tick is seen.
    task automatic run_conv(input string tag, input logic [3:0] d3, d2, d1, d0,
                            input int exp_bin, input int exp_err, input int exp_lat,
                            input bit noise);
        int  k;
        bit  seen;
        @(negedge clk);
        check_val({tag, "_pre_ready"}, ready, 1);
        bcd3 = d3; bcd2 = d2; bcd1 = d1; bcd0 = d0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        k = 0;
        seen = 1'b0;
        for (int c = 0; c < 40 && !seen; c++) begin
            if (done_tick) begin
                seen = 1'b1;
            end else begin
                check_val({tag, "_busy_ready"}, ready, 0);
                if (noise) begin
                    start = 1'b1;
                    bcd3 = 4'($urandom_range(0, 15));
                    bcd2 = 4'($urandom_range(0, 15));
                    bcd1 = 4'($urandom_range(0, 15));
                    bcd0 = 4'($urandom_range(0, 15));
                end
                @(negedge clk);
                k++;
            end
        end
        start = 1'b0;
        check_val({tag, "_done_seen"}, seen, 1);
        check_val({tag, "_latency"}, k, exp_lat);
        check_val({tag, "_bin"}, bin, exp_bin);
        check_val({tag, "_err"}, err, exp_err);
        check_val({tag, "_done_ready"}, ready, 0);
        @(negedge clk);
        check_val({tag, "_tick_width"}, done_tick, 0);
        check_val({tag, "_ready_back"}, ready, 1);
        check_val({tag, "_bin_hold"}, bin, exp_bin);
        check_val({tag, "_err_hold"}, err, exp_err);
    endtask

    initial begin
        int ticks;
        reset_n = 1'b0;
        start   = 1'b0;
        bcd3 = 4'd0; bcd2 = 4'd0; bcd1 = 4'd0; bcd0 = 4'd0;
        #2;
        check_val("rst_ready", ready, 1);
        check_val("rst_done", done_tick, 0);
        check_val("rst_bin", bin, 0);
        check_val("rst_err", err, 0);
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        repeat (2) @(negedge clk);
        check_val("idle_ready", ready, 1);
        check_val("idle_done", done_tick, 0);

        reset_n = 1'b0;
        #1;
        check_val("idle_rst_ready", ready, 1);
        check_val("idle_rst_done", done_tick, 0);
        check_val("idle_rst_bin", bin, 0);
        check_val("idle_rst_err", err, 0);
        @(negedge clk);
        reset_n = 1'b1;

        run_conv("c9999", 4'd9, 4'd9, 4'd9, 4'd9, 9999, 0, 14, 1'b0);
        run_conv("c1234", 4'd1, 4'd2, 4'd3, 4'd4, 1234, 0, 14, 1'b0);
        run_conv("c0000", 4'd0, 4'd0, 4'd0, 4'd0, 0,    0, 14, 1'b0);
        run_conv("c0010", 4'd0, 4'd0, 4'd1, 4'd0, 10,   0, 14, 1'b0);
        run_conv("c12A4", 4'd1, 4'd2, 4'hA, 4'd4, 0,    1, 0,  1'b0);
        run_conv("c0042", 4'd0, 4'd0, 4'd4, 4'd2, 42,   0, 14, 1'b0);
        run_conv("noise", 4'd8, 4'd0, 4'd9, 4'd6, 8096, 0, 14, 1'b1);

        // Reset asserted seven cycles into a 9999 conversion.
        @(negedge clk);
        bcd3 = 4'd9; bcd2 = 4'd9; bcd1 = 4'd9; bcd0 = 4'd9;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (6) @(negedge clk);
        check_val("midop_busy", ready, 0);
        reset_n = 1'b0;
        #1;
        check_val("midop_rst_ready", ready, 1);
        check_val("midop_rst_done", done_tick, 0);
        check_val("midop_rst_bin", bin, 0);
        check_val("midop_rst_err", err, 0);
        @(negedge clk);
        reset_n = 1'b1;
        ticks = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (done_tick) ticks++;
        end
        check_val("midop_no_tick", ticks, 0);
        check_val("midop_ready", ready, 1);
        check_val("midop_bin", bin, 0);

        run_conv("c5000", 4'd5, 4'd0, 4'd0, 4'd0, 5000, 0, 14, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
